seg_capture: RTL and testbench
==============================

// Module: seg_capture
// PURPOSE
//  Receive end of the 7-segment display interface: samples a multiplexed display bus (digit select + segment lines)
//  and recovers the BCD digit shown on each position. Used for board self-check and display loopback in Tetrix.
//  Inverse of the digit->segment mapping; segments active-high, bus order seg[6:0] = {f,e,a,g,d,b,c}.
// PARAMETERS
//  NDIG        4    number of multiplexed digit positions (2..8)
//  STABLE_CYC  16   consecutive identical synchronized samples required before capture (>=2)
// PORTS
//  clk          in   1         system clock, all logic rising-edge
//  rst          in   1         asynchronous, active-high reset
//  seg_in       in   7         segment lines {f,e,a,g,d,b,c}, active-high, asynchronous to clk
//  sel_in       in   NDIG      digit select, active-high, one-hot expected, asynchronous to clk
//  clr          in   1         synchronous clear of captured state (not of synchronizers)
//  digits       out  4*NDIG    captured code per position, digit i at [4i+3:4i]
//  digit_valid  out  NDIG      position captured at least once since reset/clr
//  blank        out  NDIG      last capture of position was all-segments-off
//  frame_done   out  1         one-cycle pulse: every position captured since last pulse/clr
//  err          out  1         sticky: an illegal segment pattern was captured
// BEHAVIOUR
//  Reset: digits=0, digit_valid=0, blank=0, frame_done=0, err=0, synchronizers=0, FSM=WAIT, count=0, seen=0.
//  Sync: seg_in and sel_in each pass a 2-FF synchronizer; pair P={sel_s,seg_s} is the sampled value.
//  FSM WAIT: count increments while P equals P of previous cycle, reloads to 0 when P changes.
//   count reaching STABLE_CYC-1 with P unchanged -> capture on that edge, go HELD.
//  FSM HELD: no further capture; any change of P -> count=0, go WAIT. One capture per stable window.
//  Latency: pin change to digits update = 2 (sync) + STABLE_CYC cycles.
//  Capture ignored (no state change, FSM still -> HELD) when sel_s is zero or not one-hot.
//  Decode of seg_s (hex, bus order): 0=77 1=03 2=3E 3=1F 4=4B 5=5D 6=7D 7=13 8=7F 9=5F.
//   match -> digit value, blank[i]=0; 00 -> code 4'hF, blank[i]=1; other -> code 4'hE, blank[i]=0, err<=1.
//  Capture of position i writes digits[i], sets digit_valid[i], sets seen[i].
//  seen all-ones -> frame_done=1 next cycle and seen cleared same edge; re-capture of a seen position does not pulse.
//  clr: digits=0, digit_valid=0, blank=0, seen=0, err=0, FSM=WAIT, count=0; clr beats a coincident capture.
//  err only cleared by rst or clr. count saturates; never wraps.
//  Reset asserted mid-window: all state to reset values immediately; no partial capture survives.
// CONFIGURATION
//  SEG_CAPTURE_DP_EN defined: extra input dp_in[1] (active-high, synchronized, part of P for stability);
//   extra output dp_out[NDIG] = captured dp per position, reset/clr to 0.
//  Not defined: no dp ports; decimal point ignored entirely.
// STRUCTURE
//  Package seg_pkg: SEG_W=7, per-digit pattern localparams SEG_0..SEG_9, SEG_BLANK=7'h00,
//   CODE_BLANK=4'hF, CODE_ERR=4'hE, FSM state typedef {WAIT,HELD}.
//  Sub-module seg_pattern_decode: combinational 7-bit pattern -> {code[3:0], is_blank, is_err}.
//  Top: synchronizers, stability counter/FSM, per-position registers, frame tracker.
// TESTING
//  Reset, then sel=0001 seg=7F held 40 cycles -> digits[3:0]=8, digit_valid=0001, exactly one capture, err=0.
//  Cycle sel 0001..1000 with 3,1,4,1 (1F,03,4B,03) 32 cycles each -> digits=16'h1413, one frame_done pulse.
//  sel=0010 seg=2A stable -> digits[7:4]=E, err=1 and remains 1 until clr; clr -> all outputs 0.
//  Glitch: sel=0001 seg=5D for STABLE_CYC-1 cycles then seg=7D stable -> only 6 captured, never 5.
//  sel=0011 seg=03 stable 40 cycles -> no capture; sel=0100 seg=00 -> digits[11:8]=F, blank=0100.
//  rst pulse during stable window at count=STABLE_CYC-2 -> no capture, all outputs 0 after release.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 7-segment capture block.
//   Segment bus order is seg[6:0] = {f,e,a,g,d,b,c}, active-high.
//   SEG_0..SEG_9 : legal digit patterns in bus order
//   SEG_BLANK    : all segments off
//   CODE_BLANK   : code stored for a blank position
//   CODE_ERR     : code stored for an unrecognised pattern
//   cap_state_e  : stability FSM states
//   seg_dec_t    : decoder result {code, is_blank, is_err}
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h03;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h3E;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h4B;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h5D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h13;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic {
        WAIT,
        HELD
    } cap_state_e;

    typedef struct packed {
        logic [3:0] code;
        logic       is_blank;
        logic       is_err;
    } seg_dec_t;

endpackage

// File: rtl/seg_capture_if.sv
// seg_capture_if: display-bus side of seg_capture.
//   seg_in[6:0]      segment lines {f,e,a,g,d,b,c}, asynchronous
//   sel_in[NDIG-1:0] digit select, one-hot expected, asynchronous
//   clr              synchronous clear of captured state
//   digits           captured code per position, digit i at [4i+3:4i]
//   digit_valid      position captured since reset/clr
//   blank            last capture of position was all-off
//   frame_done       one-cycle pulse when every position has been captured
//   err              sticky illegal-pattern flag
//   dp_in / dp_out   decimal point, only with SEG_CAPTURE_DP_EN defined
// master drives the display bus, slave is the capture block.
interface seg_capture_if
    import seg_pkg::*;
#(
    parameter int NDIG = 4
);
    logic [SEG_W-1:0]    seg_in;
    logic [NDIG-1:0]     sel_in;
    logic                clr;
    logic [4*NDIG-1:0]   digits;
    logic [NDIG-1:0]     digit_valid;
    logic [NDIG-1:0]     blank;
    logic                frame_done;
    logic                err;
`ifdef SEG_CAPTURE_DP_EN
    logic                dp_in;
    logic [NDIG-1:0]     dp_out;

    modport master (
        output seg_in, sel_in, clr, dp_in,
        input  digits, digit_valid, blank, frame_done, err, dp_out
    );
    modport slave (
        input  seg_in, sel_in, clr, dp_in,
        output digits, digit_valid, blank, frame_done, err, dp_out
    );
`else
    modport master (
        output seg_in, sel_in, clr,
        input  digits, digit_valid, blank, frame_done, err
    );
    modport slave (
        input  seg_in, sel_in, clr,
        output digits, digit_valid, blank, frame_done, err
    );
`endif
endinterface

// File: rtl/seg_capture_decode.sv
// seg_pattern_decode: combinational inverse of the digit->segment mapping.
//   seg_i : 7-bit pattern in bus order {f,e,a,g,d,b,c}
//   dec_o : {code, is_blank, is_err}; blank -> CODE_BLANK, unknown -> CODE_ERR
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output seg_dec_t         dec_o
);
    always_comb begin
        dec_o.code     = CODE_ERR;
        dec_o.is_blank = 1'b0;
        dec_o.is_err   = 1'b0;
        case (seg_i)
            SEG_0:     dec_o.code = 4'd0;
            SEG_1:     dec_o.code = 4'd1;
            SEG_2:     dec_o.code = 4'd2;
            SEG_3:     dec_o.code = 4'd3;
            SEG_4:     dec_o.code = 4'd4;
            SEG_5:     dec_o.code = 4'd5;
            SEG_6:     dec_o.code = 4'd6;
            SEG_7:     dec_o.code = 4'd7;
            SEG_8:     dec_o.code = 4'd8;
            SEG_9:     dec_o.code = 4'd9;
            SEG_BLANK: begin
                dec_o.code     = CODE_BLANK;
                dec_o.is_blank = 1'b1;
            end
            default:   dec_o.is_err = 1'b1;
        endcase
    end
endmodule

// File: rtl/seg_capture.sv
// seg_capture: recovers the digit shown on each position of a multiplexed
// 7-segment display bus.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seg_capture_if.slave (segment/select inputs, clr, captured outputs)
// Parameters: NDIG positions (2..8), STABLE_CYC identical samples per capture.
// Optional: SEG_CAPTURE_DP_EN adds the decimal point to the stable pair and
// captures it per position on dp_out.
module seg_capture
    import seg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 16
)(
    input  logic             clk,
    input  logic             rst,
    seg_capture_if.slave     bus
);
    localparam int CW = $clog2(STABLE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);
`ifdef SEG_CAPTURE_DP_EN
    localparam int PW = NDIG + SEG_W + 1;
`else
    localparam int PW = NDIG + SEG_W;
`endif

    logic [SEG_W-1:0]  seg_m_q, seg_s_q;
    logic [NDIG-1:0]   sel_m_q, sel_s_q;
    logic [PW-1:0]     p_w, prev_q;
    cap_state_e        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              capture_w, do_cap_w;
    seg_dec_t          dec_w;

    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic [NDIG-1:0]   blank_q, blank_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic              frame_q, frame_d;
    logic              err_q, err_d;

`ifdef SEG_CAPTURE_DP_EN
    logic              dp_m_q, dp_s_q;
    logic [NDIG-1:0]   dp_q, dp_d;
    assign p_w = {sel_s_q, seg_s_q, dp_s_q};
`else
    assign p_w = {sel_s_q, seg_s_q};
`endif

    seg_pattern_decode u_dec (
        .seg_i (seg_s_q),
        .dec_o (dec_w)
    );

    // Stability FSM: one capture request per window of STABLE_CYC identical samples.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        capture_w = 1'b0;
        case (state_q)
            WAIT: begin
                if (p_w != prev_q) begin
                    count_d = '0;
                end else if (count_q != CNT_LAST) begin
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_LAST - 1'b1) begin
                        capture_w = 1'b1;
                        state_d   = HELD;
                    end
                end
            end
            HELD: begin
                if (p_w != prev_q) begin
                    count_d = '0;
                    state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
        if (bus.clr) begin
            state_d = WAIT;
            count_d = '0;
        end
    end

    // A request with no or multiple selects still closes the window but stores nothing.
    assign do_cap_w = capture_w && !bus.clr && $onehot(sel_s_q);

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        blank_d  = blank_q;
        err_d    = err_q | (do_cap_w & dec_w.is_err);
        frame_d  = (seen_q == '1);
        // A completed frame clears seen on the same edge the pulse is launched.
        seen_d   = (seen_q == '1) ? '0 : seen_q;
`ifdef SEG_CAPTURE_DP_EN
        dp_d     = dp_q;
`endif
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (do_cap_w && sel_s_q[i]) begin
                digits_d[4*i +: 4] = dec_w.code;
                valid_d[i]         = 1'b1;
                blank_d[i]         = dec_w.is_blank;
                seen_d[i]          = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
                dp_d[i]            = dp_s_q;
`endif
            end
        end
        if (bus.clr) begin
            digits_d = '0;
            valid_d  = '0;
            blank_d  = '0;
            seen_d   = '0;
            frame_d  = 1'b0;
            err_d    = 1'b0;
`ifdef SEG_CAPTURE_DP_EN
            dp_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m_q  <= '0;
            seg_s_q  <= '0;
            sel_m_q  <= '0;
            sel_s_q  <= '0;
            prev_q   <= '0;
            state_q  <= WAIT;
            count_q  <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
            dp_m_q   <= 1'b0;
            dp_s_q   <= 1'b0;
            dp_q     <= '0;
`endif
        end else begin
            seg_m_q  <= bus.seg_in;
            seg_s_q  <= seg_m_q;
            sel_m_q  <= bus.sel_in;
            sel_s_q  <= sel_m_q;
            prev_q   <= p_w;
            state_q  <= state_d;
            count_q  <= count_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
`ifdef SEG_CAPTURE_DP_EN
            dp_m_q   <= bus.dp_in;
            dp_s_q   <= dp_m_q;
            dp_q     <= dp_d;
`endif
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.blank       = blank_q;
    assign bus.frame_done  = frame_q;
    assign bus.err         = err_q;
`ifdef SEG_CAPTURE_DP_EN
    assign bus.dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: scoreboard bench for seg_capture (NDIG=4, STABLE_CYC=16).
// Expected captured state is produced by an independent pattern table and
// pushed when stimulus is applied; it is popped once the capture window has
// elapsed and compared with the DUT outputs.
module tb_seg_capture;
    import seg_pkg::*;

    localparam int NDIG = 4;
    localparam int S    = 16;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  blank;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_capture_if #(.NDIG(NDIG)) bus ();

    seg_capture #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_blank;
    logic        m_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_changes = 0;
    int n_frame = 0;
    bit saw5 = 1'b0;
    logic [28:0] mon_prev = '0;

    // Observes output activity between stimulus steps.
    always @(negedge clk) begin
        if (!rst && !bus.clr) begin
            if ({bus.digits, bus.digit_valid, bus.blank, bus.err} !== mon_prev)
                n_changes++;
            if (bus.frame_done === 1'b1)
                n_frame++;
            if (bus.digit_valid[0] === 1'b1 && bus.digits[3:0] === 4'h5)
                saw5 = 1'b1;
        end
        mon_prev = {bus.digits, bus.digit_valid, bus.blank, bus.err};
    end

    // Segment table in bus order {f,e,a,g,d,b,c}: returns {code, blank, err}.
    function automatic logic [5:0] ref_decode(input logic [6:0] s);
        case (s)
            7'h77: return {4'd0, 2'b00};
            7'h03: return {4'd1, 2'b00};
            7'h3E: return {4'd2, 2'b00};
            7'h1F: return {4'd3, 2'b00};
            7'h4B: return {4'd4, 2'b00};
            7'h5D: return {4'd5, 2'b00};
            7'h7D: return {4'd6, 2'b00};
            7'h13: return {4'd7, 2'b00};
            7'h7F: return {4'd8, 2'b00};
            7'h5F: return {4'd9, 2'b00};
            7'h00: return {4'hF, 2'b10};
            default: return {4'hE, 2'b01};
        endcase
    endfunction

    task automatic model_clear();
        m_digits = '0;
        m_valid  = '0;
        m_blank  = '0;
        m_err    = 1'b0;
    endtask

    // Drives one stable display value and pushes the state expected after its capture.
    task automatic drive_push(input logic [3:0] sel, input logic [6:0] seg);
        logic [5:0] d;
        bus.sel_in = sel;
        bus.seg_in = seg;
        d = ref_decode(seg);
        if ($onehot(sel)) begin
            for (int i = 0; i < NDIG; i++) begin
                if (sel[i]) begin
                    m_digits[4*i +: 4] = d[5:2];
                    m_valid[i]         = 1'b1;
                    m_blank[i]         = d[1];
                end
            end
            m_err = m_err | d[0];
        end
        sb.push_back('{digits: m_digits, valid: m_valid, blank: m_blank, err: m_err});
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.sel_in = '0;
        bus.seg_in = '0;
        bus.clr    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        sb.delete();
        repeat (S + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.sel_in = '0;
        bus.seg_in = '0;
        bus.clr    = 1'b0;
`ifdef SEG_CAPTURE_DP_EN
        bus.dp_in  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.digits !== 16'h0) begin n_bad++; $display("FAIL reset_digits got %h want 0000", bus.digits); end
        n_cmp++; if (bus.digit_valid !== 4'h0) begin n_bad++; $display("FAIL reset_valid got %b want 0000", bus.digit_valid); end
        n_cmp++; if (bus.blank !== 4'h0) begin n_bad++; $display("FAIL reset_blank got %b want 0000", bus.blank); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame got %b want 0", bus.frame_done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.err); end
        rst = 1'b0;
        model_clear();
        repeat (S + 4) @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        n_changes = 0;
        drive_push(4'b0001, 7'h7F);
        repeat (S + 1) @(negedge clk);
        n_cmp++; if (bus.digit_valid !== 4'h0) begin n_bad++; $display("FAIL basic_early got valid %b want 0000", bus.digit_valid); end
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (bus.digits !== e.digits) begin n_bad++; $display("FAIL basic_digits got %h want %h", bus.digits, e.digits); end
        n_cmp++; if (bus.digit_valid !== e.valid) begin n_bad++; $display("FAIL basic_valid got %b want %b", bus.digit_valid, e.valid); end
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL basic_err got %b want %b", bus.err, e.err); end
        repeat (40 - S - 2) @(negedge clk);
        n_cmp++; if (n_changes !== 1) begin n_bad++; $display("FAIL basic_captures got %0d want 1", n_changes); end
    endtask

    task automatic test_cycle();
        logic [6:0] pats [4];
        pats[0] = 7'h1F; pats[1] = 7'h03; pats[2] = 7'h4B; pats[3] = 7'h03;
        n_frame = 0;
        for (int p = 0; p < NDIG; p++) begin
            drive_push(4'(1 << p), pats[p]);
            repeat (32) @(negedge clk);
            e = sb.pop_front();
            n_cmp++; if (bus.digits !== e.digits) begin n_bad++; $display("FAIL cycle_digits pos %0d got %h want %h", p, bus.digits, e.digits); end
        end
        n_cmp++; if (bus.digit_valid !== 4'hF) begin n_bad++; $display("FAIL cycle_valid got %b want 1111", bus.digit_valid); end
        n_cmp++; if (n_frame !== 1) begin n_bad++; $display("FAIL cycle_frame_pulses got %0d want 1", n_frame); end
    endtask

    task automatic test_err();
        drive_push(4'b0010, 7'h2A);
        repeat (32) @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (bus.digits !== e.digits) begin n_bad++; $display("FAIL err_digits got %h want %h", bus.digits, e.digits); end
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL err_flag got %b want %b", bus.err, e.err); end
        drive_push(4'b0001, 7'h03);
        repeat (32) @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL err_sticky got %b want %b", bus.err, e.err); end
        n_cmp++; if (bus.digits !== e.digits) begin n_bad++; $display("FAIL err_next_digits got %h want %h", bus.digits, e.digits); end
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        model_clear();
        n_cmp++; if (bus.digits !== 16'h0) begin n_bad++; $display("FAIL clr_digits got %h want 0000", bus.digits); end
        n_cmp++; if (bus.digit_valid !== 4'h0) begin n_bad++; $display("FAIL clr_valid got %b want 0000", bus.digit_valid); end
        n_cmp++; if (bus.blank !== 4'h0) begin n_bad++; $display("FAIL clr_blank got %b want 0000", bus.blank); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL clr_err got %b want 0", bus.err); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL clr_frame got %b want 0", bus.frame_done); end
    endtask

    task automatic test_glitch();
        do_reset();
        saw5 = 1'b0;
        bus.sel_in = 4'b0001;
        bus.seg_in = 7'h5D;
        repeat (S - 1) @(negedge clk);
        drive_push(4'b0001, 7'h7D);
        repeat (40) @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (bus.digits !== e.digits) begin n_bad++; $display("FAIL glitch_digits got %h want %h", bus.digits, e.digits); end
        n_cmp++; if (saw5 !== 1'b0) begin n_bad++; $display("FAIL glitch_saw5 got %b want 0", saw5); end
    endtask

    task automatic test_multi();
        do_reset();
        n_changes = 0;
        drive_push(4'b0011, 7'h03);
        repeat (40) @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (n_changes !== 0) begin n_bad++; $display("FAIL multi_changes got %0d want 0", n_changes); end
        n_cmp++; if (bus.digit_valid !== e.valid) begin n_bad++; $display("FAIL multi_valid got %b want %b", bus.digit_valid, e.valid); end
        drive_push(4'b0100, 7'h00);
        repeat (32) @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (bus.digits !== e.digits) begin n_bad++; $display("FAIL blank_digits got %h want %h", bus.digits, e.digits); end
        n_cmp++; if (bus.blank !== e.blank) begin n_bad++; $display("FAIL blank_mask got %b want %b", bus.blank, e.blank); end
        n_cmp++; if (bus.err !== e.err) begin n_bad++; $display("FAIL blank_err got %b want %b", bus.err, e.err); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        bus.sel_in = 4'b0001;
        bus.seg_in = 7'h7F;
        repeat (S + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.digit_valid !== 4'h0) begin n_bad++; $display("FAIL rstmid_in_valid got %b want 0000", bus.digit_valid); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.digits !== 16'h0) begin n_bad++; $display("FAIL rstmid_digits got %h want 0000", bus.digits); end
        n_cmp++; if (bus.digit_valid !== 4'h0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0000", bus.digit_valid); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got %b want 0", bus.err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cycle();
        test_err();
        test_glitch();
        test_multi();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
